// File: rtl/decoder_onehot_seq_if.sv
// Bus bundle for decoder_onehot_seq: request inputs plus decoded outputs.
// y_n exists only when DECODER_ONEHOT_SEQ_ACTIVE_LOW_EN is defined.
interface decoder_onehot_seq_if #(
  parameter int SEL_W = 2
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             en;
  logic             load;
  logic             start;
  logic             stop;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] y;
  logic [SEL_W-1:0] idx;
  logic             busy;
  logic             wrap;
`ifdef DECODER_ONEHOT_SEQ_ACTIVE_LOW_EN
  logic [OUT_W-1:0] y_n;

  modport master (output en, load, start, stop, sel,
                  input  y, idx, busy, wrap, y_n);
  modport slave  (input  en, load, start, stop, sel,
                  output y, idx, busy, wrap, y_n);
`else
  modport master (output en, load, start, stop, sel,
                  input  y, idx, busy, wrap);
  modport slave  (input  en, load, start, stop, sel,
                  output y, idx, busy, wrap);
`endif
endinterface

// File: rtl/decoder_onehot_seq.sv
// Registered N-to-2^N one-hot decoder with HOLD and dwell-timed SCAN modes.
// Optional macro DECODER_ONEHOT_SEQ_ACTIVE_LOW_EN adds registered y_n = ~y.
module decoder_onehot_seq #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_onehot_seq_if.slave  bus
);
  localparam int OUT_W   = 2 ** SEL_W;
  localparam int DW      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] idx_reg, idx_next;
  logic [OUT_W-1:0] y_reg, y_next;
  logic [DW-1:0]    dwell_reg, dwell_next;
  logic             wrap_reg, wrap_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      y_reg     <= '0;
      dwell_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      y_reg     <= y_next;
      dwell_reg <= dwell_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Holding everything while en is low also drops requests seen during freeze.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    y_next     = y_reg;
    dwell_next = dwell_reg;
    wrap_next  = 1'b0;
    if (bus.en) begin
      if (bus.stop) begin
        state_next = IDLE;
        y_next     = '0;
      end else if (bus.start) begin
        state_next = SCAN;
        idx_next   = bus.sel;
        y_next     = OUT_W'(1) << bus.sel;
        dwell_next = '0;
      end else if (bus.load) begin
        state_next = HOLD;
        idx_next   = bus.sel;
        y_next     = OUT_W'(1) << bus.sel;
      end else if (state_reg == SCAN) begin
        if (dwell_reg == DWELL_LAST) begin
          dwell_next = '0;
          idx_next   = idx_reg + 1'b1;
          y_next     = {y_reg[OUT_W-2:0], y_reg[OUT_W-1]};
          wrap_next  = (idx_reg == IDX_LAST);
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
      end
    end
  end

`ifdef DECODER_ONEHOT_SEQ_ACTIVE_LOW_EN
  logic [OUT_W-1:0] y_n_reg;

  // Kept as its own flop so y_n has the same register timing as y.
  always_ff @(posedge clk) begin
    if (!rst_n) y_n_reg <= '1;
    else        y_n_reg <= ~y_next;
  end

  assign bus.y_n = y_n_reg;
`endif

  assign bus.y    = y_reg;
  assign bus.idx  = idx_reg;
  assign bus.busy = (state_reg != IDLE);
  assign bus.wrap = wrap_reg;
endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Self-checking bench for decoder_onehot_seq (SEL_W=2, DWELL=2): directed
// scenarios followed by random requests, compared against a timing model.
module tb_decoder_onehot_seq;
  localparam int SEL_W = 2;
  localparam int DWELL = 2;
  localparam int OUT_W = 2 ** SEL_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_onehot_seq_if #(.SEL_W(SEL_W)) bus ();

  decoder_onehot_seq #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: mode 0=idle 1=hold 2=scan. In scan the index is derived
  // from the start index and the number of enabled cycles since start.
  int m_mode  = 0;
  int m_idx   = 0;
  int m_base  = 0;
  int m_t     = 0;
  int m_wrap  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic sp, input logic st,
                      input logic ld, input int s);
    int exp_y;
    rst_n     = r;
    bus.en    = e;
    bus.stop  = sp;
    bus.start = st;
    bus.load  = ld;
    bus.sel   = SEL_W'(s);
    @(posedge clk);
    cyc++;
    if (!r) begin
      m_mode = 0; m_idx = 0; m_wrap = 0;
    end else if (!e) begin
      m_wrap = 0;
    end else if (sp) begin
      m_mode = 0; m_wrap = 0;
    end else if (st) begin
      m_mode = 2; m_base = s; m_t = 0; m_idx = s; m_wrap = 0;
    end else if (ld) begin
      m_mode = 1; m_idx = s; m_wrap = 0;
    end else if (m_mode == 2) begin
      m_t++;
      m_idx  = (m_base + m_t / DWELL) % OUT_W;
      m_wrap = ((m_t % DWELL) == 0 && m_idx == 0) ? 1 : 0;
    end else begin
      m_wrap = 0;
    end
    #1;
    exp_y = (m_mode != 0) ? (1 << m_idx) : 0;
    check("y",    32'(bus.y),    32'(exp_y));
    check("idx",  32'(bus.idx),  32'(m_idx));
    check("busy", 32'(bus.busy), 32'(m_mode != 0));
    check("wrap", 32'(bus.wrap), 32'(m_wrap));
`ifdef DECODER_ONEHOT_SEQ_ACTIVE_LOW_EN
    check("y_n",  32'(bus.y_n),  32'((~exp_y) & ((1 << OUT_W) - 1)));
`endif
    $display("[TB] cyc=%0d rst_n=%b en=%b stp=%b sta=%b ld=%b sel=%0d -> y=%b idx=%0d busy=%b wrap=%b",
             cyc, r, e, sp, st, ld, s, bus.y, bus.idx, bus.busy, bus.wrap);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    // Reset at power-up.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
`ifdef DECODER_ONEHOT_SEQ_ACTIVE_LOW_EN
    check("y_n_reset", 32'(bus.y_n), 32'(4'b1111));
`endif

    // Reset asserted during an active scan.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    idle_cycles(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("rst_mid_scan_y", 32'(bus.y), 32'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Direct decode of each index.
    for (int s = 0; s < OUT_W; s++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, s);
      check("load_onehot", 32'(bus.y), 32'(1) << s);
    end
`ifdef DECODER_ONEHOT_SEQ_ACTIVE_LOW_EN
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    check("y_n_load1", 32'(bus.y_n), 32'(4'b1101));
`endif
    idle_cycles(3);

    // Scan with wrap from index 2.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    idle_cycles(8);

    // Freeze mid-dwell, with requests presented while frozen.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    idle_cycles(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    idle_cycles(5);

    // Priority resolution.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2);
    check("prio_stop_y", 32'(bus.y), 32'(0));
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    check("prio_start_idx", 32'(bus.idx), 32'(3));
    idle_cycles(6);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic r, e, sp, st, ld;
      r  = ($urandom_range(0, 99) >= 2);
      e  = ($urandom_range(0, 99) >= 12);
      sp = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 8);
      ld = ($urandom_range(0, 99) < 8);
      step(r, e, sp, st, ld, int'($urandom_range(0, OUT_W - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
